debounce_scan: RTL and testbench

- Multi-channel debounce controller. One shared prescaler and one sequencing FSM serve N_CH inputs, so the design does not need one full-width debounce counter per input.
- On each prescaler tick, the FSM visits the channels round-robin, one per clock.
- Each channel keeps a small stability counter and produces a debounced level plus one-cycle rise/fall event pulses.
- Sits between raw board inputs (buttons, link-status pins) and the transceiver control/status logic.

---
 rtl/debounce_scan.sv | 137 +++++++++++++
 tb/tb_debounce_scan.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/debounce_scan.sv
// Multi-channel debouncer: shared prescaler + round-robin scan FSM, per-channel stability counters.
// Latency: 2 sync cycles + tick wait + (STABLE_CNT-1) tick periods + idx+1 cycles to o_deb/o_rise/o_fall.
// Backpressure: none; i_en=0 freezes tick generation, a started scan always runs to completion.
module debounce_scan #(
  parameter int N_CH        = 4,
  parameter int PRESC_WIDTH = 8,
  parameter int STABLE_CNT  = 4
) (
  input  logic            i_clk,
  input  logic            i_arst_n,
  input  logic [N_CH-1:0] i_sig,
  input  logic            i_en,
  output logic [N_CH-1:0] o_deb,
  output logic [N_CH-1:0] o_rise,
  output logic [N_CH-1:0] o_fall,
  output logic            o_busy
);

  localparam int CW = $clog2(STABLE_CNT) + 1;
  localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_CH - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  logic [N_CH-1:0]        sync1_q, sync2_q;
  logic [PRESC_WIDTH-1:0] presc_q;
  logic                   tick;
  state_t                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [CW-1:0]          cnt_q [N_CH];
  logic [CW-1:0]          cnt_d [N_CH];
  logic [N_CH-1:0]        deb_q, deb_d;
  logic [N_CH-1:0]        rise_q, rise_d;
  logic [N_CH-1:0]        fall_q, fall_d;

  // Two-flop synchronizer on every raw input bit.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= i_sig;
      sync2_q <= sync1_q;
    end
  end

  // Free-running prescaler, frozen while disabled; wraps naturally at all-ones.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      presc_q <= '0;
    end else if (i_en) begin
      presc_q <= presc_q + PRESC_WIDTH'(1);
    end
  end

  assign tick = i_en && (presc_q == '1);

  // Scan sequencer: a tick in IDLE starts a walk over all channels, one per clock.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        if (idx_q == IDX_LAST) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Evaluate the channel under the scan pointer; all other channels hold.
  always_comb begin
    deb_d  = deb_q;
    cnt_d  = cnt_q;
    rise_d = '0;
    fall_d = '0;
    if (state_q == SCAN) begin
      for (int k = 0; k < N_CH; k++) begin
        if (idx_q == IW'(k)) begin
          if (sync2_q[k] == deb_q[k]) begin
            cnt_d[k] = '0;
          end else if (cnt_q[k] == CNT_LAST) begin
            deb_d[k]  = sync2_q[k];
            cnt_d[k]  = '0;
            rise_d[k] = sync2_q[k];
            fall_d[k] = ~sync2_q[k];
          end else begin
            cnt_d[k] = cnt_q[k] + CW'(1);
          end
        end
      end
    end
  end

  // State, pointer, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      deb_q   <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      for (int k = 0; k < N_CH; k++) begin
        cnt_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      deb_q   <= deb_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      for (int k = 0; k < N_CH; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign o_deb  = deb_q;
  assign o_rise = rise_q;
  assign o_fall = fall_q;
  assign o_busy = (state_q == SCAN);

endmodule

// File: tb/tb_debounce_scan.sv
// Directed bench for debounce_scan (N_CH=4, PRESC_WIDTH=4, STABLE_CNT=3).
// Expected edge events are queued by the stimulus with their hand-computed cycle; a monitor pops them.
// Cycle numbering: cyc counts rising edges since the last reset release; inputs change at falling edges.
module tb_debounce_scan;

  logic       clk = 1'b0;
  logic       arst_n;
  logic [3:0] sig;
  logic       en;
  logic [3:0] deb, rise, fall;
  logic       busy;

  int cyc;
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] deb;
    int         cyc;
  } exp_t;

  exp_t sb[$];

  debounce_scan #(
    .N_CH(4),
    .PRESC_WIDTH(4),
    .STABLE_CNT(3)
  ) dut (
    .i_clk(clk),
    .i_arst_n(arst_n),
    .i_sig(sig),
    .i_en(en),
    .o_deb(deb),
    .o_rise(rise),
    .o_fall(fall),
    .o_busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [3:0] r, input logic [3:0] f, input logic [3:0] d, input int c);
    exp_t e;
    e.rise = r;
    e.fall = f;
    e.deb  = d;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic at_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (cyc != n) begin
      total++;
      bad++;
      $display("FAIL at_cyc: reached cycle %0d, wanted %0d", cyc, n);
    end
  endtask

  task automatic do_reset(input logic [3:0] s, input logic e);
    @(negedge clk);
    arst_n = 1'b0;
    sig    = s;
    en     = e;
    repeat (3) @(negedge clk);
    arst_n = 1'b1;
  endtask

  // Monitor: every edge event must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (arst_n === 1'b1 && (rise | fall) != 4'b0000) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: rise=%b fall=%b deb=%b at cycle %0d, none required", rise, fall, deb, cyc);
      end else begin
        e = sb.pop_front();
        check("ev_rise", rise, e.rise);
        check("ev_fall", fall, e.fall);
        check("ev_deb", deb, e.deb);
        check("ev_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    int first;
    arst_n = 1'b0;
    sig    = 4'b0000;
    en     = 1'b0;
    #12;
    check("reset_outputs", {deb, rise, fall, busy}, 32'h0);

    // 1: steady 0010; ch1 toggles in scan 3 (starts at cycle 48), evaluated at 49, visible at 50.
    do_reset(4'b0010, 1'b1);
    push(4'b0010, 4'b0000, 4'b0010, 50);
    nb = 0;
    first = -1;
    for (int c = 1; c <= 47; c++) begin
      at_cyc(c);
      if (busy === 1'b1) begin
        nb++;
        if (first < 0) first = c;
      end
    end
    check("t1_busy_cycles", nb, 8);
    check("t1_first_busy", first, 16);
    at_cyc(49);
    check("t1_deb_before", deb, 4'b0000);
    at_cyc(50);
    check("t1_deb_after", deb, 4'b0010);
    at_cyc(80);
    check("t1_deb_hold", deb, 4'b0010);
    check("t1_sb_empty", sb.size(), 0);

    // 2: 20-cycle pulse on ch2 seen by two scans (cycles 34 and 50) only.
    do_reset(4'b0000, 1'b1);
    at_cyc(30);
    sig = 4'b0100;
    at_cyc(50);
    sig = 4'b0000;
    at_cyc(120);
    check("t2_deb", deb, 4'b0000);
    check("t2_sb_empty", sb.size(), 0);

    // 3: all channels rise in scan 3, then all fall in the third scan after release.
    do_reset(4'b1111, 1'b1);
    push(4'b0001, 4'b0000, 4'b0001, 49);
    push(4'b0010, 4'b0000, 4'b0011, 50);
    push(4'b0100, 4'b0000, 4'b0111, 51);
    push(4'b1000, 4'b0000, 4'b1111, 52);
    at_cyc(53);
    check("t3_deb_high", deb, 4'b1111);
    at_cyc(60);
    sig = 4'b0000;
    push(4'b0000, 4'b0001, 4'b1110, 97);
    push(4'b0000, 4'b0010, 4'b1100, 98);
    push(4'b0000, 4'b0100, 4'b1000, 99);
    push(4'b0000, 4'b1000, 4'b0000, 100);
    at_cyc(110);
    check("t3_deb_low", deb, 4'b0000);
    check("t3_sb_empty", sb.size(), 0);

    // 4: prescaler frozen for 100 cycles; after enabling, ticks at 115/131/147 -> rise at 149.
    do_reset(4'b0001, 1'b0);
    nb = 0;
    for (int c = 1; c <= 100; c++) begin
      at_cyc(c);
      if (busy === 1'b1) nb++;
    end
    check("t4_busy_frozen", nb, 0);
    check("t4_deb_frozen", deb, 4'b0000);
    en = 1'b1;
    push(4'b0001, 4'b0000, 4'b0001, 149);
    at_cyc(148);
    check("t4_deb_before", deb, 4'b0000);
    at_cyc(160);
    check("t4_deb_after", deb, 4'b0001);
    check("t4_sb_empty", sb.size(), 0);

    // 5: ch3 has two disagreeing samples; reset inside scan 3 must discard them.
    do_reset(4'b1000, 1'b1);
    at_cyc(49);
    check("t5_busy_mid_scan", busy, 1'b1);
    arst_n = 1'b0;
    #1;
    check("t5_async_clear", {deb, rise, fall, busy}, 32'h0);
    repeat (2) @(negedge clk);
    arst_n = 1'b1;
    push(4'b1000, 4'b0000, 4'b1000, 52);
    at_cyc(51);
    check("t5_deb_before", deb, 4'b0000);
    at_cyc(70);
    check("t5_deb_after", deb, 4'b1000);
    check("t5_sb_empty", sb.size(), 0);

    // 6: ch1 alternates between successive scan samples, never two disagreements in a row.
    do_reset(4'b0010, 1'b1);
    for (int m = 0; m < 8; m++) begin
      at_cyc(24 + 16 * m);
      sig[1] = ~sig[1];
    end
    at_cyc(140);
    sig = 4'b0000;
    at_cyc(180);
    check("t6_deb", deb, 4'b0000);
    check("t6_sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
